dmem_arbiter: RTL

Two-requester controller for the single-port `data_memory`, which has a combinational read and a synchronous write. It arbitrates round-robin between the CPU load/store unit (port 0) and the loader/debug port (port 1), holding one transaction outstanding at a time. It turns byte and halfword accesses into word accesses: loads are extracted and sign/zero-extended, and sub-word stores become read-modify-write. Misaligned requests are rejected with an error response and never touch memory.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_lane.sv | 67 ++++++
 rtl/dmem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, state enum and alignment rule for the data-memory arbiter.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    ERR    = 3'd5
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        we;
    logic        uns;
    logic        owner;
  } cmd_t;

  // Only the two low address bits can make an access misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] rmw_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the memory word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = mem_rdata[7:0];
      2'b01:   byte_s = mem_rdata[15:8];
      2'b10:   byte_s = mem_rdata[23:16];
      2'b11:   byte_s = mem_rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Sign- or zero-extend the extracted field to a full word.
  always_comb begin
    load_data = 32'h0000_0000;
    case (size)
      SZ_BYTE: load_data = uns ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SZ_HALF: load_data = uns ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      SZ_WORD: load_data = mem_rdata;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Replace the target lane(s) of the previously read word with store data.
  always_comb begin
    merge_data = rmw_word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'b00:   merge_data = {rmw_word[31:8], wdata[7:0]};
          2'b01:   merge_data = {rmw_word[31:16], wdata[7:0], rmw_word[7:0]};
          2'b10:   merge_data = {rmw_word[31:24], wdata[7:0], rmw_word[15:0]};
          2'b11:   merge_data = {wdata[7:0], rmw_word[23:0]};
          default: merge_data = rmw_word;
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) begin
          merge_data = {wdata[15:0], rmw_word[15:0]};
        end else begin
          merge_data = {rmw_word[31:16], wdata[15:0]};
        end
      end
      SZ_WORD: merge_data = wdata;
      default: merge_data = rmw_word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port controller for a single-port data memory with
// sub-word load extension, read-modify-write stores and misalignment errors.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [1:0]  req0_size,
  input  logic        req0_unsigned,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [1:0]  req1_size,
  input  logic        req1_unsigned,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  state_t      state_r, state_nx_s;
  cmd_t        cmd_r;
  logic        rr_ptr_r;
  logic [31:0] rmw_word_r;

  logic        gnt0_s, gnt1_s, idle_s, accept_s;
  logic        sel_we_s, sel_uns_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic [1:0]  sel_size_s;
  logic [31:0] load_data_s, merge_data_s;
  logic        fin_s, resp_err_s;
  logic [31:0] resp_data_s;

  logic        resp0_valid_r, resp0_err_r, resp1_valid_r, resp1_err_r;
  logic [31:0] resp0_rdata_r, resp1_rdata_r;

  // Round-robin grant; rr_ptr only breaks ties when both ports are valid.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0_s = ~rr_ptr_r;
      gnt1_s = rr_ptr_r;
    end else begin
      gnt0_s = req0_valid;
      gnt1_s = req1_valid;
    end
  end

  assign idle_s     = (state_r == IDLE);
  assign req0_ready = idle_s & req0_valid & gnt0_s;
  assign req1_ready = idle_s & req1_valid & gnt1_s;
  assign accept_s   = req0_ready | req1_ready;

  // Route the granted port's request fields toward the command register.
  always_comb begin
    sel_addr_s  = req0_addr;
    sel_wdata_s = req0_wdata;
    sel_size_s  = req0_size;
    sel_we_s    = req0_we;
    sel_uns_s   = req0_unsigned;
    if (gnt1_s) begin
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
      sel_size_s  = req1_size;
      sel_we_s    = req1_we;
      sel_uns_s   = req1_unsigned;
    end else begin
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
      sel_size_s  = req0_size;
      sel_we_s    = req0_we;
      sel_uns_s   = req0_unsigned;
    end
  end

  // Next-state decode; the alignment check happens on the incoming request.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nx_s = IDLE;
        end else if (misaligned(sel_size_s, sel_addr_s[1:0])) begin
          state_nx_s = ERR;
        end else if (!sel_we_s) begin
          state_nx_s = LOAD;
        end else if (sel_size_s == SZ_WORD) begin
          state_nx_s = WRITE;
        end else begin
          state_nx_s = RMW_RD;
        end
      end
      LOAD:    state_nx_s = IDLE;
      WRITE:   state_nx_s = IDLE;
      RMW_RD:  state_nx_s = RMW_WR;
      RMW_WR:  state_nx_s = IDLE;
      ERR:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  dmem_lane u_lane (
    .addr_lo    (cmd_r.addr[1:0]),
    .size       (cmd_r.size),
    .uns        (cmd_r.uns),
    .mem_rdata  (mem_rdata),
    .rmw_word   (rmw_word_r),
    .wdata      (cmd_r.wdata),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // Memory strobes depend on state alone so a reset kills a pending write.
  always_comb begin
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_we    = 1'b0;
    if (idle_s) begin
      mem_addr = 32'h0000_0000;
    end else begin
      mem_addr = {cmd_r.addr[31:2], 2'b00};
    end
    case (state_r)
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = cmd_r.wdata;
      end
      RMW_WR: begin
        mem_we    = 1'b1;
        mem_wdata = merge_data_s;
      end
      default: begin
        mem_we    = 1'b0;
        mem_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Response payload produced by whichever state ends the transaction.
  always_comb begin
    fin_s       = 1'b0;
    resp_data_s = 32'h0000_0000;
    resp_err_s  = 1'b0;
    case (state_r)
      LOAD: begin
        fin_s       = 1'b1;
        resp_data_s = load_data_s;
      end
      WRITE:   fin_s = 1'b1;
      RMW_WR:  fin_s = 1'b1;
      ERR: begin
        fin_s      = 1'b1;
        resp_err_s = 1'b1;
      end
      default: fin_s = 1'b0;
    endcase
  end

  // FSM state, arbitration pointer and command capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rr_ptr_r   <= 1'b0;
      cmd_r      <= '0;
      rmw_word_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        rr_ptr_r    <= gnt0_s;
        cmd_r.addr  <= sel_addr_s;
        cmd_r.wdata <= sel_wdata_s;
        cmd_r.size  <= sel_size_s;
        cmd_r.we    <= sel_we_s;
        cmd_r.uns   <= sel_uns_s;
        cmd_r.owner <= gnt1_s;
      end
      if (state_r == RMW_RD) begin
        rmw_word_r <= mem_rdata;
      end
    end
  end

  // One-cycle registered response, routed to the owning port only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid_r <= 1'b0;
      resp0_rdata_r <= 32'h0000_0000;
      resp0_err_r   <= 1'b0;
      resp1_valid_r <= 1'b0;
      resp1_rdata_r <= 32'h0000_0000;
      resp1_err_r   <= 1'b0;
    end else begin
      resp0_valid_r <= fin_s & ~cmd_r.owner;
      resp0_rdata_r <= (fin_s & ~cmd_r.owner) ? resp_data_s : 32'h0000_0000;
      resp0_err_r   <= fin_s & ~cmd_r.owner & resp_err_s;
      resp1_valid_r <= fin_s & cmd_r.owner;
      resp1_rdata_r <= (fin_s & cmd_r.owner) ? resp_data_s : 32'h0000_0000;
      resp1_err_r   <= fin_s & cmd_r.owner & resp_err_s;
    end
  end

  assign resp0_valid = resp0_valid_r;
  assign resp0_rdata = resp0_rdata_r;
  assign resp0_err   = resp0_err_r;
  assign resp1_valid = resp1_valid_r;
  assign resp1_rdata = resp1_rdata_r;
  assign resp1_err   = resp1_err_r;

endmodule
